button_debounce_pulse: RTL and testbench

//  Conditions N raw, asynchronous, bouncing, active-high push-buttons into clean

---
 rtl/button_debounce_pulse.sv | 114 +++++++++++
 tb/tb_button_debounce_pulse.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/button_debounce_pulse.sv
// Debounces N raw push-buttons and turns each accepted press into a single-cycle pulse,
// alongside a registered debounced level per channel.
module button_debounce_pulse #(
  parameter int N_BUTTONS       = 3,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [N_BUTTONS-1:0] i_btn_raw,
  output logic [N_BUTTONS-1:0] o_button,
  output logic [N_BUTTONS-1:0] o_level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  logic [N_BUTTONS-1:0] sync1_r;
  logic [N_BUTTONS-1:0] sync2_r;

  // Two-flop synchronizer bringing the asynchronous button levels into i_clk
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= i_btn_raw;
      sync2_r <= sync1_r;
    end
  end

  for (genvar k = 0; k < N_BUTTONS; k++) begin : g_chan
    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             button_r;
    logic             level_r;
    logic             btn_s;

    assign btn_s       = sync2_r[k];
    assign o_button[k] = button_r;
    assign o_level[k]  = level_r;

    // Debounce FSM; outputs are updated on the same edge as the state they reflect
    always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
        state_r  <= ST_IDLE;
        cnt_r    <= '0;
        button_r <= 1'b0;
        level_r  <= 1'b0;
      end else begin
        button_r <= 1'b0;
        case (state_r)
          ST_IDLE: begin
            level_r <= 1'b0;
            if (btn_s) begin
              state_r <= ST_PRESS_WAIT;
              cnt_r   <= '0;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_PRESS_WAIT: begin
            if (!btn_s) begin
              state_r <= ST_IDLE;
              cnt_r   <= '0;
            end else if (cnt_r == CNT_LAST) begin
              state_r  <= ST_PRESSED;
              cnt_r    <= '0;
              button_r <= 1'b1;
              level_r  <= 1'b1;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
          ST_PRESSED: begin
            level_r <= 1'b1;
            if (!btn_s) begin
              state_r <= ST_RELEASE_WAIT;
              cnt_r   <= '0;
            end else begin
              state_r <= ST_PRESSED;
            end
          end
          ST_RELEASE_WAIT: begin
            // A bounce back to pressed re-enters PRESSED silently: no second pulse
            if (btn_s) begin
              state_r <= ST_PRESSED;
              cnt_r   <= '0;
            end else if (cnt_r == CNT_LAST) begin
              state_r <= ST_IDLE;
              cnt_r   <= '0;
              level_r <= 1'b0;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            level_r <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Self-checking bench for button_debounce_pulse: directed vector table, reset corner
// cases and randomized holds/bounces checked against a run-length reference model.
module tb_button_debounce_pulse;

  localparam int N = 3;
  localparam int D = 4;

  logic         i_clk = 1'b0;
  logic         i_reset = 1'b0;
  logic [N-1:0] i_btn_raw = 3'b000;
  logic [N-1:0] o_button;
  logic [N-1:0] o_level;

  always #5 i_clk = ~i_clk;

  button_debounce_pulse #(.N_BUTTONS(N), .DEBOUNCE_CYCLES(D)) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_btn_raw(i_btn_raw),
    .o_button (o_button),
    .o_level  (o_level)
  );

  int checks = 0;
  int passes = 0;

  // Reference model: a channel's level flips once the synchronized input has
  // disagreed with it on D+1 consecutive edges; a 0->1 flip is a press pulse.
  logic [N-1:0] cur_raw;
  logic [N-1:0] m_s1, m_s2, m_btn, m_lvl;
  int           m_run [N];

  typedef struct {
    logic [N-1:0] raw;
    logic [N-1:0] btn;
    logic [N-1:0] lvl;
  } vec_t;
  vec_t vecs[$];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_btn = '0; m_lvl = '0;
    for (int k = 0; k < N; k++) m_run[k] = 0;
  endtask

  task automatic model_edge();
    if (!i_reset) begin
      model_reset();
    end else begin
      m_btn = '0;
      for (int k = 0; k < N; k++) begin
        if (m_s2[k] != m_lvl[k]) m_run[k] = m_run[k] + 1;
        else m_run[k] = 0;
        if (m_run[k] == D + 1) begin
          m_lvl[k] = m_s2[k];
          m_btn[k] = m_s2[k];
          m_run[k] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = cur_raw;
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step(input logic [N-1:0] raw);
    i_btn_raw = raw;
    cur_raw   = raw;
    @(posedge i_clk);
    model_edge();
    @(negedge i_clk);
    cmp("model_button", 32'(o_button), 32'(m_btn));
    cmp("model_level", 32'(o_level), 32'(m_lvl));
  endtask

  // n cycles of a constant raw value; pulse expected on cycle 7, level switches at cycle 7
  task automatic add_run(input logic [N-1:0] raw, input int n, input logic [N-1:0] pulse,
                         input logic [N-1:0] lvl_before, input logic [N-1:0] lvl_after);
    vec_t v;
    for (int s = 1; s <= n; s++) begin
      v.raw = raw;
      v.btn = (s == 7) ? pulse : 3'b000;
      v.lvl = (s < 7) ? lvl_before : lvl_after;
      vecs.push_back(v);
    end
  endtask

  initial begin
    logic [N-1:0] rnd_raw;
    int           hold [N];
    int           pulses;

    // press and release of btn[1]
    add_run(3'b010, 10, 3'b010, 3'b000, 3'b010);
    add_run(3'b000, 8, 3'b000, 3'b010, 3'b000);
    // one-cycle toggling on btn[0]
    add_run(3'b001, 1, 3'b000, 3'b000, 3'b000);
    add_run(3'b000, 1, 3'b000, 3'b000, 3'b000);
    add_run(3'b001, 1, 3'b000, 3'b000, 3'b000);
    add_run(3'b000, 7, 3'b000, 3'b000, 3'b000);
    // btn[2] press, release bounce, clean release
    add_run(3'b100, 10, 3'b100, 3'b000, 3'b100);
    add_run(3'b000, 2, 3'b000, 3'b100, 3'b100);
    add_run(3'b100, 8, 3'b000, 3'b100, 3'b100);
    add_run(3'b000, 8, 3'b000, 3'b100, 3'b000);
    // simultaneous press on bits 0 and 2
    add_run(3'b101, 8, 3'b101, 3'b000, 3'b101);
    add_run(3'b000, 8, 3'b000, 3'b101, 3'b000);

    cur_raw = 3'b000;
    model_reset();
    for (int i = 0; i < 3; i++) step(3'b000);
    i_reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step(3'b000);
      cmp("idle_button", 32'(o_button), 32'd0);
      cmp("idle_level", 32'(o_level), 32'd0);
    end

    foreach (vecs[i]) begin
      step(vecs[i].raw);
      cmp("tbl_button", 32'(o_button), 32'(vecs[i].btn));
      cmp("tbl_level", 32'(o_level), 32'(vecs[i].lvl));
    end

    // reset while btn[0] is held and btn[1] is mid press-wait
    for (int i = 0; i < 8; i++) step(3'b001);
    cmp("pre_rst_level", 32'(o_level), 32'd1);
    for (int i = 0; i < 4; i++) step(3'b011);
    i_btn_raw = 3'b010;
    cur_raw   = 3'b010;
    i_reset   = 1'b0;
    #1;
    model_reset();
    cmp("rst_async_button", 32'(o_button), 32'd0);
    cmp("rst_async_level", 32'(o_level), 32'd0);
    step(3'b010);
    step(3'b010);
    i_reset = 1'b1;
    pulses = 0;
    for (int s = 1; s <= 12; s++) begin
      step(3'b010);
      if (o_button[1]) pulses++;
      cmp("post_rst_button", 32'(o_button), (s == 7) ? 32'd2 : 32'd0);
      cmp("post_rst_level", 32'(o_level), (s >= 7) ? 32'd2 : 32'd0);
    end
    cmp("post_rst_pulse_count", 32'(pulses), 32'd1);

    // random holds of 1..9 cycles per channel: mixes bounces and real presses
    rnd_raw = 3'b000;
    for (int k = 0; k < N; k++) hold[k] = 0;
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < N; k++) begin
        if (hold[k] == 0) begin
          rnd_raw[k] = 1'($urandom_range(0, 1));
          hold[k]    = int'($urandom_range(1, 9));
        end
        hold[k] = hold[k] - 1;
      end
      step(rnd_raw);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
